// File: rtl/prog_loader.sv
// Serial program loader: parses an address/length/payload/checksum byte stream from a host,
// writes each payload byte to memory with a setup/strobe/hold cycle, then releases the CPU.
module prog_loader #(
    parameter int unsigned WRITE_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_run,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic [15:0] o_addr_out,
    output logic [7:0]  o_data_out,
    output logic        o_assert_bar,
    output logic        o_we_bar,
    output logic        o_cpu_rst_bar,
    output logic        o_done,
    output logic        o_error
);

    typedef enum logic [3:0] {
        StIdle,
        StAddrHi,
        StAddrLo,
        StLenHi,
        StLenLo,
        StData,
        StWSetup,
        StWStrobe,
        StWHold,
        StCheck,
        StDone,
        StErr
    } state_e;

    localparam logic [3:0] LP_STROBE_LAST = 4'(WRITE_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [15:0] r_addr;
    logic [15:0] r_len;
    logic [7:0]  r_data;
    logic [7:0]  r_sum;
    logic [3:0]  r_cnt;
    logic        w_accept;

    assign w_accept   = o_in_ready & i_in_valid;
    assign o_addr_out = r_addr;
    assign o_data_out = r_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_in_ready    = 1'b0;
        o_assert_bar  = 1'b1;
        o_we_bar      = 1'b1;
        o_cpu_rst_bar = 1'b0;
        o_done        = 1'b0;
        o_error       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StAddrHi;
                end else if (i_run) begin
                    w_state_nxt = StDone;
                end
            end
            StAddrHi: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_state_nxt = StAddrLo;
            end
            StAddrLo: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_state_nxt = StLenHi;
            end
            StLenHi: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_state_nxt = StLenLo;
            end
            StLenLo: begin
                o_in_ready = 1'b1;
                // Zero-length load skips straight to the checksum byte.
                if (i_in_valid) begin
                    w_state_nxt = ({r_len[15:8], i_in_data} != 16'd0) ? StData : StCheck;
                end
            end
            StData: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_state_nxt = StWSetup;
            end
            StWSetup: begin
                o_assert_bar = 1'b0;
                w_state_nxt  = StWStrobe;
            end
            StWStrobe: begin
                o_assert_bar = 1'b0;
                o_we_bar     = 1'b0;
                if (r_cnt == LP_STROBE_LAST) w_state_nxt = StWHold;
            end
            StWHold: begin
                o_assert_bar = 1'b0;
                w_state_nxt  = (r_len != 16'd1) ? StData : StCheck;
            end
            StCheck: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_state_nxt = (i_in_data == r_sum) ? StDone : StErr;
            end
            StDone: begin
                o_cpu_rst_bar = 1'b1;
                o_done        = 1'b1;
            end
            StErr: begin
                o_error = 1'b1;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= 16'h0000;
            r_len  <= 16'h0000;
            r_data <= 8'h00;
            r_sum  <= 8'h00;
            r_cnt  <= 4'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) r_sum <= 8'h00;
                end
                StAddrHi: begin
                    if (w_accept) r_addr[15:8] <= i_in_data;
                end
                StAddrLo: begin
                    if (w_accept) r_addr[7:0] <= i_in_data;
                end
                StLenHi: begin
                    if (w_accept) r_len[15:8] <= i_in_data;
                end
                StLenLo: begin
                    if (w_accept) r_len[7:0] <= i_in_data;
                end
                StData: begin
                    if (w_accept) begin
                        r_data <= i_in_data;
                        r_sum  <= r_sum + i_in_data;
                    end
                end
                StWSetup: begin
                    r_cnt <= 4'd0;
                end
                StWStrobe: begin
                    r_cnt <= r_cnt + 4'd1;
                end
                StWHold: begin
                    // Bus values move only after the hold cycle; address wraps naturally.
                    r_addr <= r_addr + 16'd1;
                    r_len  <= r_len - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes are queued as stimulus is driven
// and matched against each observed WE_bar strobe.
module tb_prog_loader;

    localparam int unsigned WC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        run;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] addr_out;
    logic [7:0]  data_out;
    logic        assert_bar;
    logic        we_bar;
    logic        cpu_rst_bar;
    logic        done;
    logic        error;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] sb[$];
    logic [7:0]  stream[$];
    logic        prev_we = 1'b1;
    int          strobe_len = 0;
    logic [15:0] cap_addr = 16'h0;
    logic [7:0]  cap_data = 8'h0;
    logic        rst_cut = 1'b0;

    always #5 clk = ~clk;

    prog_loader #(.WRITE_CYCLES(WC)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_run        (run),
        .i_in_data    (in_data),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .o_addr_out   (addr_out),
        .o_data_out   (data_out),
        .o_assert_bar (assert_bar),
        .o_we_bar     (we_bar),
        .o_cpu_rst_bar(cpu_rst_bar),
        .o_done       (done),
        .o_error      (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle bus monitor; matches strobes against the scoreboard.
    task automatic mon();
        logic [23:0] e;
        if (!we_bar) chk("assert_during_strobe", 32'(assert_bar), 32'd0);
        if (prev_we && !we_bar) begin
            chk("write_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 32'(addr_out), 32'(e[23:8]));
                chk("wr_data", 32'(data_out), 32'(e[7:0]));
            end
            cap_addr   = addr_out;
            cap_data   = data_out;
            strobe_len = 1;
        end else if (!prev_we && !we_bar) begin
            strobe_len++;
            chk("addr_stable", 32'(addr_out), 32'(cap_addr));
            chk("data_stable", 32'(data_out), 32'(cap_data));
        end else if (!prev_we && we_bar) begin
            if (!rst_cut) chk("strobe_width", 32'(strobe_len), 32'(WC));
            rst_cut = 1'b0;
        end
        prev_we = we_bar;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        mon();
    endtask

    task automatic send(input logic [7:0] b, input int max_gap);
        int   g;
        int   i;
        logic ok;
        g        = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        in_valid = 1'b0;
        repeat (g) tick();
        in_valid = 1'b1;
        in_data  = b;
        ok       = 1'b0;
        i        = 0;
        while (!ok && i < 100) begin
            ok = in_ready;
            tick();
            i++;
        end
        in_valid = 1'b0;
        chk("byte_accepted", 32'(ok), 32'd1);
    endtask

    task automatic send_stream(input int max_gap);
        foreach (stream[k]) send(stream[k], max_gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_addr", 32'(addr_out), 32'h0000);
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_assert_bar", 32'(assert_bar), 32'd1);
        chk("rst_we_bar", 32'(we_bar), 32'd1);
        chk("rst_cpu_rst_bar", 32'(cpu_rst_bar), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset();
    endtask

    task automatic chk_end(input logic exp_done);
        chk("done", 32'(done), 32'(exp_done));
        chk("cpu_rst_bar", 32'(cpu_rst_bar), 32'(exp_done));
        chk("error", 32'(error), 32'(!exp_done));
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int i;
        rst      = 1'b1;
        start    = 1'b0;
        run      = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset();

        // Two-byte load at 0x1234, checksum 0xFF.
        pulse_start();
        sb.push_back({16'h1234, 8'hAA});
        sb.push_back({16'h1235, 8'h55});
        stream = '{8'h12, 8'h34, 8'h00, 8'h02, 8'hAA, 8'h55, 8'hFF};
        send_stream(0);
        chk_end(1'b1);
        pulse_start();
        chk("done_ignores_start", 32'(in_ready), 32'd0);
        chk("done_held", 32'(done), 32'd1);

        // Address wrap at 0xFFFF.
        do_reset();
        pulse_start();
        sb.push_back({16'hFFFF, 8'h01});
        sb.push_back({16'h0000, 8'h02});
        stream = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03};
        send_stream(0);
        chk_end(1'b1);

        // Bad checksum after one write.
        do_reset();
        pulse_start();
        sb.push_back({16'h0010, 8'h07});
        stream = '{8'h00, 8'h10, 8'h00, 8'h01, 8'h07, 8'h08};
        send_stream(0);
        chk_end(1'b0);
        tick();
        tick();
        chk("err_sticky", 32'(error), 32'd1);

        // Zero length, good then bad checksum.
        do_reset();
        pulse_start();
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(0);
        chk_end(1'b1);
        do_reset();
        pulse_start();
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        send_stream(0);
        chk_end(1'b0);

        // RUN releases the CPU immediately.
        do_reset();
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("run_done", 32'(done), 32'd1);
        chk("run_cpu_rst_bar", 32'(cpu_rst_bar), 32'd1);
        chk("run_assert_bar", 32'(assert_bar), 32'd1);

        // START wins over RUN.
        do_reset();
        start = 1'b1;
        run   = 1'b1;
        tick();
        start = 1'b0;
        run   = 1'b0;
        chk("start_wins_ready", 32'(in_ready), 32'd1);
        chk("start_wins_done", 32'(done), 32'd0);

        // START/RUN coincident with RST are dropped.
        do_reset();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("start_with_rst", 32'(in_ready), 32'd0);
        rst = 1'b1;
        run = 1'b1;
        tick();
        rst = 1'b0;
        run = 1'b0;
        tick();
        chk("run_with_rst", 32'(done), 32'd0);

        // Gapped stream, reset mid-strobe, then a clean reload.
        pulse_start();
        sb.push_back({16'h1234, 8'hAA});
        stream = '{8'h12, 8'h34, 8'h00, 8'h03, 8'hAA};
        send_stream(3);
        i = 0;
        while (we_bar && i < 20) begin
            tick();
            i++;
        end
        chk("strobe_seen", 32'(we_bar), 32'd0);
        tick();
        rst_cut = 1'b1;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        chk("we_after_rst", 32'(we_bar), 32'd1);
        chk_reset();
        pulse_start();
        sb.push_back({16'h0020, 8'h11});
        sb.push_back({16'h0021, 8'h22});
        stream = '{8'h00, 8'h20, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        send_stream(3);
        chk_end(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
